ram_store_align: RTL and testbench
==================================

Name: ram_store_align

Overview:
- Store-side alignment engine between the CPU store path and the RAM write port.
- Accepts a byte address, access size and LSB-aligned store data; emits RAM-word writes with rotated data and byte enables.
- An access that crosses a RAM-word boundary is split into two consecutive write beats.
- Parametrised in RAM data width; valid/ready handshake on both sides; registered output.

Parameters:
- DATA_BYTES, 4, RAM word width in bytes; power of two, >= 2.
- ADDR_W, 16, RAM word-address width.
- OFF_W, $clog2(DATA_BYTES), derived: byte-offset width; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_addr  in  ADDR_W+OFF_W  byte address; upper ADDR_W bits are the word address, lower OFF_W bits the offset.
- in_size  in  2  log2 of access bytes: 0=byte, 1=word, 2=long, 3=quad.
- in_data  in  8*DATA_BYTES  store data, LSB-aligned; bytes above the size are ignored.
- out_valid  out  1  write beat valid.
- out_ready  in  1  RAM accepts the beat.
- out_addr  out  ADDR_W  RAM word address of the beat.
- out_data  out  8*DATA_BYTES  rotated write data.
- out_be  out  DATA_BYTES  byte enables.
- out_last  out  1  final beat of this request.
- out_err  out  1  request illegal (size > DATA_BYTES); beat carries out_be=0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; out_valid, out_last, out_err and busy = 0; out_addr, out_data and out_be = 0. Any pending beat is discarded and the request is not replayed.
- Byte count nb = 1<<in_size.
- Mask: m = ((1<<nb)-1) << off, 2*DATA_BYTES wide.
  - Beat0 be = m[DATA_BYTES-1:0].
  - Beat1 be = m[2*DATA_BYTES-1:DATA_BYTES].
  - Split iff the beat1 half is nonzero.
- Data: in_data masked to nb bytes, then rotated left (not shifted) by 8*off bits. The same rotated word is presented on both beats; spilled bytes land in the low lanes for beat1.
- Addresses: beat0 = word address; beat1 = word address + 1 modulo 2^ADDR_W (wraps to 0).
- Illegal size (nb > DATA_BYTES): single beat, out_be=0, out_err=1, out_last=1; data is don't-care.
- States:
  - IDLE: no beat held. in_ready=1. On accept, load beat0 and go to BEAT0.
  - BEAT0: out_valid=1. out_last=1 iff no split.
    - On out_ready with split: load beat1, go to BEAT1, in_ready=0.
    - On out_ready without split: if in_valid, accept and load the new beat0, stay in BEAT0; else go to IDLE.
    - in_ready = out_ready && !split.
  - BEAT1: out_valid=1, out_last=1. in_ready = out_ready. On out_ready: back-to-back accept into BEAT0, else IDLE.
- Latency: accept edge -> out_valid on the next cycle.
- Throughput: one aligned request per cycle under continuous out_ready; a split request costs 2 cycles.
- Output registers are stable while out_valid && !out_ready.
- Request fields are registered on accept; later in_* changes have no effect on beats in flight.

Decomposition:
- pkg_ram gains:
  - RAM_DATA_BYTES.
  - RAM_SIZE_BYTE, RAM_SIZE_WORD, RAM_SIZE_LONG, RAM_SIZE_QUAD as a 2-bit enum typedef ram_size_t.
  - A state enum typedef ram_align_state_t.
- One combinational sub-module, byte_rotl (parametrised DATA_BYTES: data, offset -> rotated data), replaces the fixed 4-byte shifter.
- The mask generator stays inline.

Test Plan:
- DATA_BYTES=4, byte store, addr 0x0007, data 0xAB -> one beat: addr 0x0001, data 0xAB000000, be 1000, last=1.
- Long store, addr 0x0006, data 0x11223344 -> beat0: addr 1, data 0x33441122, be 1100, last=0; then beat1: addr 2, same data, be 0011, last=1.
- Backpressure: out_ready held low 3 cycles in BEAT0 of a split store -> outputs unchanged, in_ready=0; the beat1 sequence completes after release.
- Wrap: ADDR_W=16, word store at byte addr 0x3FFFF (offset 3), data 0xBEEF -> beat0: addr 0xFFFF, be 1000; beat1: addr 0x0000, be 0001.
- Quad store with DATA_BYTES=4 -> single beat: out_err=1, be 0000, last=1. DATA_BYTES=8 rerun, quad at offset 4 -> two beats, be 0xF0 then 0x0F.
- Reset asserted asynchronously mid-BEAT1 -> out_valid=0 and busy=0 immediately. The next request after reset is handled normally; 10 back-to-back aligned longs are accepted one per cycle.

Source files
------------

// File: rtl/ram_store_align_pkg.sv
// Shared types and constants for the RAM store-side alignment engine.
package ram_store_align_pkg;

  localparam int RAM_DATA_BYTES = 4;

  typedef enum logic [1:0] {
    RAM_SIZE_BYTE = 2'd0,
    RAM_SIZE_WORD = 2'd1,
    RAM_SIZE_LONG = 2'd2,
    RAM_SIZE_QUAD = 2'd3
  } ram_size_t;

  typedef enum logic [1:0] {
    RAM_ST_IDLE  = 2'd0,
    RAM_ST_BEAT0 = 2'd1,
    RAM_ST_BEAT1 = 2'd2
  } ram_align_state_t;

  function automatic int size_bytes(input ram_size_t s);
    return 1 << s;
  endfunction

endpackage

// File: rtl/ram_store_align_rotl.sv
// Byte-granular rotate-left of a RAM word by a byte offset.
module byte_rotl #(
  parameter  int DATA_BYTES = 4,
  localparam int OFF_W      = $clog2(DATA_BYTES)
) (
  input  logic [8*DATA_BYTES-1:0] data_i,
  input  logic [OFF_W-1:0]        off_i,
  output logic [8*DATA_BYTES-1:0] data_o
);

  logic [16*DATA_BYTES-1:0] dbl;

  // Shifting a doubled word left and keeping the upper half is a rotate.
  assign dbl    = {data_i, data_i} << {off_i, 3'b000};
  assign data_o = dbl[16*DATA_BYTES-1:8*DATA_BYTES];

endmodule

// File: rtl/ram_store_align.sv
// Store alignment engine: turns byte-addressed stores into RAM-word write
// beats, splitting accesses that straddle a word boundary into two beats.
module ram_store_align
  import ram_store_align_pkg::*;
#(
  parameter  int DATA_BYTES = RAM_DATA_BYTES,
  parameter  int ADDR_W     = 16,
  localparam int OFF_W      = $clog2(DATA_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W+OFF_W-1:0] in_addr,
  input  logic [1:0]              in_size,
  input  logic [8*DATA_BYTES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [8*DATA_BYTES-1:0] out_data,
  output logic [DATA_BYTES-1:0]   out_be,
  output logic                    out_last,
  output logic                    out_err,
  output logic                    busy
);

  ram_align_state_t state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [8*DATA_BYTES-1:0] data_q, data_d;
  logic [DATA_BYTES-1:0]   be_q, be_d;
  logic [DATA_BYTES-1:0]   be1_q, be1_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;

  int                      nb;
  logic                    illegal;
  logic [OFF_W-1:0]        off;
  logic [8*DATA_BYTES-1:0] data_masked;
  logic [8*DATA_BYTES-1:0] data_rot;
  logic [2*DATA_BYTES-1:0] req_mask;

  always_comb begin
    nb      = size_bytes(ram_size_t'(in_size));
    illegal = nb > DATA_BYTES;
    off     = in_addr[OFF_W-1:0];
    for (int i = 0; i < DATA_BYTES; i++) begin
      data_masked[8*i +: 8] = (i < nb) ? in_data[8*i +: 8] : 8'h00;
    end
    // Illegal sizes produce an empty mask, which also suppresses the split.
    for (int i = 0; i < 2*DATA_BYTES; i++) begin
      req_mask[i] = !illegal && (i >= int'(off)) && (i < int'(off) + nb);
    end
  end

  byte_rotl #(.DATA_BYTES(DATA_BYTES)) u_rotl (
    .data_i (data_masked),
    .off_i  (off),
    .data_o (data_rot)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    be1_d    = be1_q;
    last_d   = last_q;
    err_d    = err_q;
    in_ready = 1'b0;

    unique case (state_q)
      RAM_ST_IDLE:  in_ready = 1'b1;
      RAM_ST_BEAT0: in_ready = out_ready && last_q;
      RAM_ST_BEAT1: in_ready = out_ready;
      default:      in_ready = 1'b0;
    endcase

    if (state_q == RAM_ST_BEAT0 && out_ready && !last_q) begin
      state_d = RAM_ST_BEAT1;
      addr_d  = addr_q + ADDR_W'(1);
      be_d    = be1_q;
      be1_d   = '0;
      last_d  = 1'b1;
      err_d   = 1'b0;
    end else if (in_ready && in_valid) begin
      state_d = RAM_ST_BEAT0;
      addr_d  = in_addr[ADDR_W+OFF_W-1:OFF_W];
      data_d  = data_rot;
      be_d    = req_mask[DATA_BYTES-1:0];
      be1_d   = req_mask[2*DATA_BYTES-1:DATA_BYTES];
      last_d  = req_mask[2*DATA_BYTES-1:DATA_BYTES] == '0;
      err_d   = illegal;
    end else if (state_q != RAM_ST_IDLE && out_ready) begin
      state_d = RAM_ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RAM_ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      be1_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      be1_q   <= be1_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = state_q != RAM_ST_IDLE;
  assign busy      = state_q != RAM_ST_IDLE;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_be    = be_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ram_store_align.sv
// Directed self-checking bench for ram_store_align (DATA_BYTES=4 and 8).
module tb_ram_store_align;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DATA_BYTES = 4 instance
  logic        in_valid = 1'b0, in_ready;
  logic [17:0] in_addr  = '0;
  logic [1:0]  in_size  = '0;
  logic [31:0] in_data  = '0;
  logic        out_valid, out_last, out_err, busy;
  logic        out_ready = 1'b1;
  logic [15:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;

  ram_store_align #(.DATA_BYTES(4), .ADDR_W(16)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_size(in_size), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_be(out_be), .out_last(out_last),
    .out_err(out_err), .busy(busy)
  );

  // DATA_BYTES = 8 instance
  logic        in_valid8 = 1'b0, in_ready8;
  logic [18:0] in_addr8  = '0;
  logic [1:0]  in_size8  = '0;
  logic [63:0] in_data8  = '0;
  logic        out_valid8, out_last8, out_err8, busy8;
  logic        out_ready8 = 1'b1;
  logic [15:0] out_addr8;
  logic [63:0] out_data8;
  logic [7:0]  out_be8;

  ram_store_align #(.DATA_BYTES(8), .ADDR_W(16)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_addr(in_addr8),
    .in_size(in_size8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_addr(out_addr8),
    .out_data(out_data8), .out_be(out_be8), .out_last(out_last8),
    .out_err(out_err8), .busy(busy8)
  );

  // Beat view packed as {valid, addr, data, be, last, err}.
  logic [54:0] obs4;
  assign obs4 = {out_valid, out_addr, out_data, out_be, out_last, out_err};

  task automatic send4(input logic [17:0] a, input logic [1:0] s, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_addr = a; in_size = s; in_data = d;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send4_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({out_valid, out_last, out_err, busy, out_addr, out_data, out_be} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {out_valid, out_last, out_err, busy, out_addr, out_data, out_be});
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_byte;
    out_ready = 1'b1;
    send4(18'h00007, 2'd0, 32'h000000AB);
    @(negedge clk);
    total++;
    if (obs4 !== {1'b1, 16'h0001, 32'hAB000000, 4'b1000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL byte_beat got=%h want=%h", obs4, {1'b1, 16'h0001, 32'hAB000000, 4'b1000, 1'b1, 1'b0});
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL byte_idle out_valid=%b want=0", out_valid); end
  endtask

  task automatic test_split;
    out_ready = 1'b1;
    send4(18'h00006, 2'd2, 32'h11223344);
    @(negedge clk);
    total++;
    if (obs4 !== {1'b1, 16'h0001, 32'h33441122, 4'b1100, 1'b0, 1'b0}) begin
      bad++; $display("FAIL split_beat0 got=%h want=%h", obs4, {1'b1, 16'h0001, 32'h33441122, 4'b1100, 1'b0, 1'b0});
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL split_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    total++;
    if (obs4 !== {1'b1, 16'h0002, 32'h33441122, 4'b0011, 1'b1, 1'b0}) begin
      bad++; $display("FAIL split_beat1 got=%h want=%h", obs4, {1'b1, 16'h0002, 32'h33441122, 4'b0011, 1'b1, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send4(18'h00006, 2'd2, 32'h11223344);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (obs4 !== {1'b1, 16'h0001, 32'h33441122, 4'b1100, 1'b0, 1'b0} || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%h rdy=%b want=%h rdy=0", c, obs4, in_ready,
                        {1'b1, 16'h0001, 32'h33441122, 4'b1100, 1'b0, 1'b0});
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_release_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    total++;
    if (obs4 !== {1'b1, 16'h0002, 32'h33441122, 4'b0011, 1'b1, 1'b0} || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_beat1 got=%h rdy=%b want=%h rdy=1", obs4, in_ready,
                      {1'b1, 16'h0002, 32'h33441122, 4'b0011, 1'b1, 1'b0});
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle out_valid=%b want=0", out_valid); end
  endtask

  task automatic test_wrap;
    out_ready = 1'b1;
    send4(18'h3FFFF, 2'd1, 32'h0000BEEF);
    @(negedge clk);
    total++;
    if (obs4 !== {1'b1, 16'hFFFF, 32'hEF0000BE, 4'b1000, 1'b0, 1'b0}) begin
      bad++; $display("FAIL wrap_beat0 got=%h want=%h", obs4, {1'b1, 16'hFFFF, 32'hEF0000BE, 4'b1000, 1'b0, 1'b0});
    end
    @(negedge clk);
    total++;
    if (obs4 !== {1'b1, 16'h0000, 32'hEF0000BE, 4'b0001, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_beat1 got=%h want=%h", obs4, {1'b1, 16'h0000, 32'hEF0000BE, 4'b0001, 1'b1, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    send4(18'h00004, 2'd3, 32'h12345678);
    @(negedge clk);
    total++;
    if ({out_valid, out_addr, out_be, out_last, out_err} !== {1'b1, 16'h0001, 4'b0000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL illegal_beat got=%h want=%h", {out_valid, out_addr, out_be, out_last, out_err},
                      {1'b1, 16'h0001, 4'b0000, 1'b1, 1'b1});
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_single out_valid=%b want=0", out_valid); end
  endtask

  task automatic test_quad8;
    int n = 0;
    @(negedge clk);
    in_valid8 = 1'b1; in_addr8 = {16'h0010, 3'd4}; in_size8 = 2'd3;
    in_data8 = 64'h0102030405060708;
    while (!in_ready8 && n < 20) begin @(negedge clk); n++; end
    if (!in_ready8) begin total++; bad++; $display("FAIL quad8_timeout in_ready=%b want=1", in_ready8); end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid8, out_addr8, out_data8, out_be8, out_last8, out_err8} !==
        {1'b1, 16'h0010, 64'h0506070801020304, 8'hF0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL quad8_beat0 addr=%h data=%h be=%h last=%b err=%b want 0010/0506070801020304/f0/0/0",
                      out_addr8, out_data8, out_be8, out_last8, out_err8);
    end
    @(negedge clk);
    total++;
    if ({out_valid8, out_addr8, out_data8, out_be8, out_last8, out_err8} !==
        {1'b1, 16'h0011, 64'h0506070801020304, 8'h0F, 1'b1, 1'b0}) begin
      bad++; $display("FAIL quad8_beat1 addr=%h data=%h be=%h last=%b err=%b want 0011/0506070801020304/0f/1/0",
                      out_addr8, out_data8, out_be8, out_last8, out_err8);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    send4(18'h00006, 2'd2, 32'h11223344);
    @(posedge clk); #2;
    total++;
    if ({busy, out_last, out_be} !== {1'b1, 1'b1, 4'b0011}) begin
      bad++; $display("FAIL ar_in_beat1 got=%b want=110011", {busy, out_last, out_be});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, out_last, out_be} !== 7'b0) begin
      bad++; $display("FAIL ar_immediate got=%b want=0000000", {out_valid, busy, out_last, out_be});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_no_replay out_valid=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        total++;
        if (obs4 !== {1'b1, 16'h0020 + 16'(k - 1), 32'hA5000000 + 32'(k - 1), 4'b1111, 1'b1, 1'b0}) begin
          bad++; $display("FAIL b2b_beat%0d got=%h want=%h", k - 1, obs4,
                          {1'b1, 16'h0020 + 16'(k - 1), 32'hA5000000 + 32'(k - 1), 4'b1111, 1'b1, 1'b0});
        end
      end
      if (k < 10) begin
        in_valid = 1'b1;
        in_addr  = {16'h0020 + 16'(k), 2'b00};
        in_size  = 2'd2;
        in_data  = 32'hA5000000 + 32'(k);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", k, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain out_valid=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_split();
    test_backpressure();
    test_wrap();
    test_illegal();
    test_quad8();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
